mult_div_unit: RTL and testbench

- Multicycle signed multiply/divide engine in the datapath, directly downstream of the control unit.
- The control unit starts an operation, selects multiply or divide with Div_Mult_Ctrl, and consumes the DIV0 flag this block raises.
- Operands come from the A and B registers.
- Results drive the external HI/LO registers, which latch them when the control unit asserts its HI/LO write signal.

---
 rtl/mult_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// mult_div_unit: multicycle signed radix-2 Booth multiplier and restoring divider.
// Drives HI/LO result registers; div0 is sticky until the next accepted start.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MULT   = 3'd1,
    S_DIV    = 3'd2,
    S_FINISH = 3'd3,
    S_DONE   = 3'd4,
    S_DZERO  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  // acc: Booth accumulator for MULT, partial remainder for DIV (one extra bit in both)
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] qreg_q, qreg_d;
  logic             qm1_q, qm1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rsh;
  logic [WIDTH:0]   trial;

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      qreg_q  <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      qreg_q  <= qreg_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    qreg_d  = qreg_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div0_d  = div0_q;
    sum     = acc_q;
    rsh     = {acc_q[WIDTH-1:0], qreg_q[WIDTH-1]};
    trial   = rsh - m_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          cnt_d  = '0;
          div0_d = 1'b0;
          acc_d  = '0;
          qm1_d  = 1'b0;
          if (!op) begin
            m_d     = {a_in[WIDTH-1], a_in};
            qreg_d  = b_in;
            state_d = S_MULT;
          end else if (b_in == '0) begin
            state_d = S_DZERO;
          end else begin
            // Divide magnitudes; -2^(W-1) maps to 2^(W-1), which fits unsigned
            m_d     = {1'b0, (b_in[WIDTH-1] ? -b_in : b_in)};
            qreg_d  = a_in[WIDTH-1] ? -a_in : a_in;
            qneg_d  = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            rneg_d  = a_in[WIDTH-1];
            state_d = S_DIV;
          end
        end
      end
      S_MULT: begin
        case ({qreg_q[0], qm1_q})
          2'b01:   sum = acc_q + m_q;
          2'b10:   sum = acc_q - m_q;
          default: sum = acc_q;
        endcase
        {acc_d, qreg_d, qm1_d} = {sum[WIDTH], sum, qreg_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FINISH;
      end
      S_DIV: begin
        if (!trial[WIDTH]) begin
          acc_d  = trial;
          qreg_d = {qreg_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d  = rsh;
          qreg_d = {qreg_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        if (op_q) begin
          lo_d = qneg_q ? -qreg_q : qreg_q;
          hi_d = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end else begin
          hi_d = acc_q[WIDTH-1:0];
          lo_d = qreg_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DZERO: begin
        div0_d  = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign div0   = div0_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// tb_mult_div_unit: directed and random checks of mult_div_unit against a
// plain-arithmetic signed reference (64-bit product, truncating / and %).
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset_in;
  logic         start;
  logic         op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;
  logic         busy;
  logic         done;
  logic         div0;

  int           n_checks;
  int           n_fail;
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy),
    .done     (done),
    .div0     (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0:       v = '0;
      1:       v = '1;
      2:       v = 32'h8000_0000;
      3:       v = 32'h7FFF_FFFF;
      4:       v = W'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one operation and check latency, handshake and result.
  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit disturb);
    longint sa, sb, p, q, r;
    logic [W-1:0] ehi, elo;
    bit dz;
    int cyc;
    int lat;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = o && (b == '0);
    if (!o) begin
      p   = sa * sb;
      ehi = p[63:32];
      elo = p[31:0];
    end else if (!dz) begin
      q   = sa / sb;
      r   = sa % sb;
      elo = q[31:0];
      ehi = r[31:0];
    end else begin
      ehi = exp_hi;
      elo = exp_lo;
    end
    lat = dz ? 1 : W + 1;

    op    = o;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("div0_cleared", div0, 1'b0);

    cyc = 0;
    while (!done && cyc < 200) begin
      if (disturb) begin
        a_in = $urandom;
        b_in = $urandom;
        if (cyc == 2 || cyc == 9) begin
          start = 1'b1;
          op    = ~o;
        end else begin
          start = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (disturb && !done) check("busy_mid_op", busy, 1'b1);
    end
    start = 1'b0;
    check("latency", cyc, lat);
    check("busy_in_done", busy, 1'b1);
    check("hi", hi_out, ehi);
    check("lo", lo_out, elo);
    check("div0", div0, dz);

    @(posedge clk);
    #1;
    check("done_pulse", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    if (dz) begin
      repeat (2) @(posedge clk);
      #1;
      check("div0_sticky", div0, 1'b1);
      check("hi_held", hi_out, ehi);
      check("lo_held", lo_out, elo);
    end
    exp_hi = ehi;
    exp_lo = elo;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_hi   = '0;
    exp_lo   = '0;
    reset_in = 1'b1;
    start    = 1'b0;
    op       = 1'b0;
    a_in     = '0;
    b_in     = '0;
    #1;
    check("rst_hi", hi_out, 0);
    check("rst_lo", lo_out, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_div0", div0, 1'b0);
    repeat (2) @(posedge clk);
    #3 reset_in = 1'b0;
    @(posedge clk);
    #1;

    run_op(1'b0, 32'd7, -32'sd3, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(1'b1, -32'sd7, 32'd2, 1'b0);
    run_op(1'b1, 32'd7, -32'sd2, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 32'd0, 32'd9, 1'b0);
    run_op(1'b0, 32'd123456, -32'sd789, 1'b0);
    run_op(1'b1, 32'd5, 32'd0, 1'b0);
    run_op(1'b0, 32'd1000, 32'd1000, 1'b1);
    run_op(1'b1, -32'sd1000001, 32'd37, 1'b1);

    for (int i = 0; i < 60; i++) begin
      run_op(1'($urandom_range(0, 1)), pick(), pick(), 1'b0);
    end

    // Asynchronous reset in the middle of a divide
    run_op(1'b0, 32'd7, -32'sd3, 1'b0);
    op    = 1'b1;
    a_in  = 32'h7654_3210;
    b_in  = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #3 reset_in = 1'b1;
    #1;
    check("arst_hi", hi_out, 0);
    check("arst_lo", lo_out, 0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_div0", div0, 1'b0);
    @(posedge clk);
    #3 reset_in = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle", busy, 1'b0);
    exp_hi = '0;
    exp_lo = '0;
    run_op(1'b0, 32'd3, 32'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
